// File: rtl/moore_observer_pkg.sv
// Shared definitions for the 7-segment sequence observer: state encoding,
// the tracked digit sequence and the active-low segment patterns.
package moore_observer_pkg;

    typedef enum logic [1:0] {SYNC, LOCK, BLANK, ERR} state_t;

    localparam logic [3:0] BLANK_CODE = 4'd15;
    localparam logic [3:0] NO_POS     = 4'd15;
    localparam logic [6:0] BLANK_PAT  = 7'b1111111;

    // Patterns are written a..g from left to right, active low.
    localparam logic [6:0] DIGIT_PAT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    // Tracked sequence 9,4,6,5,8,2,1,0,5 (cyclic, length 9).
    function automatic logic [3:0] seq_at(input logic [3:0] p);
        case (p)
            4'd0:    seq_at = 4'd9;
            4'd1:    seq_at = 4'd4;
            4'd2:    seq_at = 4'd6;
            4'd3:    seq_at = 4'd5;
            4'd4:    seq_at = 4'd8;
            4'd5:    seq_at = 4'd2;
            4'd6:    seq_at = 4'd1;
            4'd7:    seq_at = 4'd0;
            4'd8:    seq_at = 4'd5;
            default: seq_at = BLANK_CODE;
        endcase
    endfunction

    // Index of a digit in the sequence; 5 is ambiguous and 3/7 never occur,
    // so those return NO_POS.
    function automatic logic [3:0] seq_index(input logic [3:0] d);
        case (d)
            4'd9:    seq_index = 4'd0;
            4'd4:    seq_index = 4'd1;
            4'd6:    seq_index = 4'd2;
            4'd8:    seq_index = 4'd4;
            4'd2:    seq_index = 4'd5;
            4'd1:    seq_index = 4'd6;
            4'd0:    seq_index = 4'd7;
            default: seq_index = NO_POS;
        endcase
    endfunction

endpackage

// File: rtl/moore_observer_seg_to_bcd.sv
// Combinational decode of an active-low 7-segment pattern into a digit,
// blank (15) or an illegal flag.
module seg_to_bcd
    import moore_observer_pkg::*;
(
    input  logic [0:6] seg,
    output logic [3:0] value,
    output logic       legal
);

    always_comb begin
        value = BLANK_CODE;
        legal = (seg == BLANK_PAT);
        for (int i = 0; i < 10; i++) begin
            if (seg == DIGIT_PAT[i]) begin
                value = 4'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/moore_observer.sv
// Observes a 7-segment display and infers up/down/resync steps of the
// counter driving it by tracking its position in a fixed digit sequence.
module moore_observer
    import moore_observer_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Tick,
    input  logic [0:6] Segmentos,
    output logic [3:0] Digito,
    output logic       Valido,
    output logic       Up,
    output logic       Down,
    output logic       Resync,
    output logic       Erro,
    output logic [3:0] Posicao
);

    state_t     state, state_next;
    logic [3:0] pos, pos_next, pos_inc, pos_dec;
    logic [3:0] value;
    logic       legal;
    logic       up_next, down_next, resync_next;
    logic [3:0] digito_q;
    logic       valido_q, up_q, down_q, resync_q;

    seg_to_bcd u_dec (
        .seg   (Segmentos),
        .value (value),
        .legal (legal)
    );

    assign pos_inc = (pos == 4'd8) ? 4'd0 : pos + 4'd1;
    assign pos_dec = (pos == 4'd0) ? 4'd8 : pos - 4'd1;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= SYNC;
            pos      <= 4'd0;
            digito_q <= 4'd0;
            valido_q <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            state    <= state_next;
            pos      <= pos_next;
            up_q     <= up_next;
            down_q   <= down_next;
            resync_q <= resync_next;
            if (Tick) begin
                valido_q <= legal;
                if (legal)
                    digito_q <= value;
            end
        end
    end

    always_comb begin
        state_next  = state;
        pos_next    = pos;
        up_next     = 1'b0;
        down_next   = 1'b0;
        resync_next = 1'b0;
        if (Tick) begin
            case (state)
                // ERR leaves by the same rules as SYNC; an ambiguous 5 holds it.
                SYNC, ERR: begin
                    if (!legal)
                        state_next = ERR;
                    else if (value == BLANK_CODE)
                        state_next = BLANK;
                    else if (value == 4'd5)
                        state_next = state;
                    else if (seq_index(value) != NO_POS) begin
                        state_next = LOCK;
                        pos_next   = seq_index(value);
                    end else
                        state_next = ERR;
                end
                LOCK: begin
                    if (!legal)
                        state_next = ERR;
                    else if (value == seq_at(pos)) begin
                        state_next = LOCK;
                    end else if (value == seq_at(pos_inc)) begin
                        pos_next = pos_inc;
                        up_next  = 1'b1;
                    end else if (value == seq_at(pos_dec)) begin
                        pos_next  = pos_dec;
                        down_next = 1'b1;
                    end else if (value == 4'd9) begin
                        pos_next    = 4'd0;
                        resync_next = 1'b1;
                    end else if (value == BLANK_CODE) begin
                        state_next = BLANK;
                        up_next    = 1'b1;
                        down_next  = 1'b1;
                    end else
                        state_next = ERR;
                end
                BLANK: begin
                    if (legal && value == BLANK_CODE)
                        state_next = BLANK;
                    else if (legal && value == 4'd9) begin
                        state_next = LOCK;
                        pos_next   = 4'd0;
                    end else
                        state_next = ERR;
                end
                default: state_next = SYNC;
            endcase
        end
    end

    assign Digito  = digito_q;
    assign Valido  = valido_q;
    assign Up      = up_q;
    assign Down    = down_q;
    assign Resync  = resync_q;
    assign Erro    = (state == ERR);
    assign Posicao = (state == LOCK) ? pos : NO_POS;

endmodule

// File: doc/moore_observer.md
MOORE_OBSERVER -- requirements
Module: moore_observer

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single system clock, all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Tick, input, 1 bit: one-cycle sample strobe from the frequency divider.
REQ-004 SHALL have port Segmentos, input, 7 bits [0:6]: active-low 7-segment pattern (index 0 = segment a … 6 = g).
REQ-005 SHALL have port Digito, output, 4 bits: last decoded value (0-9 digit, 15 blank).
REQ-006 SHALL have port Valido, output, 1 bit: high when the last sample decoded to a legal pattern.
REQ-007 SHALL have port Up, output, 1 bit: one-cycle pulse, inferred up step.
REQ-008 SHALL have port Down, output, 1 bit: one-cycle pulse, inferred down step.
REQ-009 SHALL have port Resync, output, 1 bit: one-cycle pulse, inferred counter reset (jump to 9).
REQ-010 SHALL have port Erro, output, 1 bit: level, illegal pattern or illegal transition seen, held until relock.
REQ-011 SHALL have port Posicao, output, 4 bits: tracked sequence index 0-8, 15 when not locked.

Function
REQ-012 Decode SHALL map patterns 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,0000000,0000100 to 0-9, 1111111 to 15 (blank), all others illegal.
REQ-013 Segmentos SHALL be sampled only in cycles with Tick=1; all outputs SHALL update on the edge ending that cycle (latency 1); no change when Tick=0.
REQ-014 Tracked sequence SHALL be SEQ = 9,4,6,5,8,2,1,0,5 (index 0-8), cyclic mod 9.
REQ-015 FSM states SHALL be SYNC, LOCK, BLANK, ERR.
REQ-016 SYNC: blank -> BLANK; 5 -> stay SYNC (ambiguous); other legal digit d -> LOCK, Posicao = index of d in SEQ; illegal -> ERR.
REQ-017 LOCK at p: digit = SEQ[p] -> stay, no pulse; SEQ[(p+1) mod 9] -> p+1, Up pulse; SEQ[(p+8) mod 9] -> p-1, Down pulse.
REQ-018 LOCK: otherwise 9 -> p=0, Resync pulse; blank -> BLANK, Up and Down both pulsed; any other value -> ERR.
REQ-019 Wrap-around: p=8 with 9 SHALL be Up (p=0); p=0 with 5 SHALL be Down (p=8), not SYNC.
REQ-020 BLANK: blank -> stay, no pulse; 9 -> LOCK p=0, no pulse; other -> ERR.
REQ-021 ERR: Erro=1; exits by SYNC rules (REQ-016), illegal keeps ERR; Erro SHALL clear on entering LOCK or BLANK.
REQ-022 Posicao SHALL read 15 in SYNC, BLANK and ERR.
REQ-023 Up, Down and Resync SHALL never be high for more than one cycle per Tick.
REQ-024 Valido SHALL be 0 and Digito SHALL hold its previous value on an illegal sample.

Reset
REQ-025 Reset=1 SHALL force state SYNC, Digito=0, Valido=0, Up=0, Down=0, Resync=0, Erro=0, Posicao=15, asynchronously.
REQ-026 Reset SHALL override Tick; a Tick coincident with Reset SHALL be discarded.
REQ-027 After Reset release, the first sample SHALL be processed by SYNC rules.

Structure
REQ-028 A shared package SHALL hold state encodings, the SEQ table, the ten digit patterns and the BLANK constant.
REQ-029 The pattern decode SHALL be a combinational sub-module seg_to_bcd (Segmentos in; 4-bit value and legal flag out).
REQ-030 The FSM, position register and pulse registers SHALL be in moore_observer.

Verification
REQ-031 Reset, then Ticks with patterns for 9,4,6,5 -> LOCK p=0, then Up pulses, Posicao 1,2,3.
REQ-032 In LOCK p=8 (5), Tick 9 -> Up pulse, p=0; Tick 5 -> Down pulse, p=8.
REQ-033 From SYNC, Tick 5 -> stay SYNC, Posicao=15, no pulses; then Tick 8 -> LOCK p=4.
REQ-034 LOCK p=2 (6), Tick blank -> BLANK with Up=Down=1 for one cycle; Tick 9 -> LOCK p=0, no pulse.
REQ-035 LOCK p=2, Tick 1111110 (illegal) -> ERR, Erro=1, Valido=0; Tick 9 -> LOCK p=0, Erro=0.
REQ-036 LOCK p=5, Tick 9 -> Resync pulse, p=0; assert Reset mid-stream -> all outputs at REQ-025 values immediately.
